// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then performs a byte-masked write or a read and pulses a one-cycle response.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  wen_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;

    logic        req_ready_q;
    logic        busy_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [31:0] mem_q [DEPTH];

    logic [29:0] acc_addr_d;
    logic [3:0]  acc_wen_d;
    logic        acc_err_d;
    logic [31:0] acc_rdata_d;
    logic        wr_en;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr[1:0];

    // In IDLE the access about to enter RESP is the one on the request pins
    // (only reachable with WAIT_CYCLES == 0); otherwise it is the latched one.
    always_comb begin
        acc_addr_d  = (state_q == ST_IDLE) ? req_addr[31:2] : addr_q;
        acc_wen_d   = (state_q == ST_IDLE) ? req_wen : wen_q;
        acc_err_d   = |acc_addr_d[29:ADDR_WIDTH];
        acc_rdata_d = '0;
        if (!acc_err_d && (acc_wen_d == '0)) begin
            acc_rdata_d = mem_q[acc_addr_d[ADDR_WIDTH-1:0]];
        end
    end

    // State leaves RESP asynchronously on reset, so an aborted write never lands.
    assign wr_en = (state_q == ST_RESP) && (wen_q != '0) && !resp_err_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wen_q[b]) begin
                    mem_q[addr_q[ADDR_WIDTH-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wen_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        wen_q       <= req_wen;
                        addr_q      <= req_addr[31:2];
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES);
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= acc_err_d;
                            resp_rdata_q <= acc_rdata_d;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= acc_err_d;
                        resp_rdata_q <= acc_rdata_d;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none, checked against hand-computed values.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, resp_valid, resp_err, busy;
    logic [3:0]  req_wen;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        d0_req_valid, d0_req_ready, d0_resp_valid, d0_resp_err, d0_busy;
    logic [3:0]  d0_req_wen;
    logic [31:0] d0_req_addr, d0_req_wdata, d0_resp_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy)
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_wen(d0_req_wen),
        .req_addr(d0_req_addr), .req_wdata(d0_req_wdata),
        .resp_valid(d0_resp_valid), .resp_rdata(d0_resp_rdata), .resp_err(d0_resp_err),
        .busy(d0_busy)
    );

    // Issue one request on the main instance; returns data, error and the
    // number of cycles from the accept edge to the response cycle.
    task automatic do_txn(input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = '0; req_addr = '0; req_wdata = '0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [35:0] obs;
        rst = 1'b1;
        req_valid = 1'b0; req_wen = '0; req_addr = '0; req_wdata = '0;
        d0_req_valid = 1'b0; d0_req_wen = '0; d0_req_addr = '0; d0_req_wdata = '0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        obs = {req_ready, busy, resp_valid, resp_err, resp_rdata};
        tests_run++;
        if (obs !== {4'b1000, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", obs, {4'b1000, 32'h0});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            obs = {req_ready, busy, resp_valid, resp_err, resp_rdata};
            tests_run++;
            if (obs !== {4'b1000, 32'h0}) begin
                tests_failed++;
                $display("FAIL idle_after_reset[%0d]: got %h expected %h", i, obs, {4'b1000, 32'h0});
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        do_txn(4'hF, 32'h0000_0010, 32'hDEAD_BEEF, rd, er, lat);
        tests_run++;
        if ({lat, er, rd} !== {32'd3, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL write_resp: got lat=%0d err=%b rdata=%h expected lat=3 err=0 rdata=0", lat, er, rd);
        end
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_strobe: got resp_valid=%b expected 0", resp_valid);
        end
        do_txn(4'h0, 32'h0000_0010, 32'h0, rd, er, lat);
        tests_run++;
        if ({lat, er, rd} !== {32'd3, 1'b0, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL read_back: got lat=%0d err=%b rdata=%h expected lat=3 err=0 rdata=deadbeef", lat, er, rd);
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd; logic er; int lat;
        do_txn(4'b0101, 32'h0000_0010, 32'h1122_3344, rd, er, lat);
        do_txn(4'h0, 32'h0000_0010, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'hDE22_BE44) begin
            tests_failed++;
            $display("FAIL byte_mask: got %h expected de22be44", rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        do_txn(4'h0, 32'h0000_1000, 32'h0, rd, er, lat);
        tests_run++;
        if ({lat, er, rd} !== {32'd3, 1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL oor_read: got lat=%0d err=%b rdata=%h expected lat=3 err=1 rdata=0", lat, er, rd);
        end
        do_txn(4'hF, 32'h0000_1010, 32'hFFFF_FFFF, rd, er, lat);
        tests_run++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            tests_failed++;
            $display("FAIL oor_write: got err=%b rdata=%h expected err=1 rdata=0", er, rd);
        end
        do_txn(4'h0, 32'h0000_0010, 32'h0, rd, er, lat);
        tests_run++;
        if ({er, rd} !== {1'b0, 32'hDE22_BE44}) begin
            tests_failed++;
            $display("FAIL oor_no_alias: got err=%b rdata=%h expected err=0 rdata=de22be44", er, rd);
        end
    endtask

    task automatic test_busy_hold();
        logic [31:0] rd; logic er; int lat; int nresp;
        do_txn(4'hF, 32'h0000_0030, 32'h0BAD_F00D, rd, er, lat);
        req_valid = 1'b1; req_wen = 4'h0; req_addr = 32'h30; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = 4'hF; req_addr = 32'h10; req_wdata = '1;
        tests_run++;
        if ({req_ready, busy, resp_valid} !== 3'b010) begin
            tests_failed++;
            $display("FAIL hold_wait1: got %b expected 010", {req_ready, busy, resp_valid});
        end
        @(posedge clk); #1;
        req_valid = 1'b1;
        tests_run++;
        if ({req_ready, busy, resp_valid} !== 3'b010) begin
            tests_failed++;
            $display("FAIL hold_wait2: got %b expected 010", {req_ready, busy, resp_valid});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({req_ready, busy, resp_valid, resp_rdata} !== {3'b011, 32'h0BAD_F00D}) begin
            tests_failed++;
            $display("FAIL hold_resp: got %b/%h expected 011/0badf00d", {req_ready, busy, resp_valid}, resp_rdata);
        end
        req_wen = 4'h0; req_addr = 32'h10; req_wdata = '0;
        @(posedge clk); #1;
        tests_run++;
        if ({req_ready, busy, resp_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL hold_idle: got %b expected 100", {req_ready, busy, resp_valid});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests_run++;
        if ({req_ready, busy, resp_valid} !== 3'b010) begin
            tests_failed++;
            $display("FAIL hold_reaccept: got %b expected 010", {req_ready, busy, resp_valid});
        end
        nresp = 0; rd = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                nresp++;
                rd = resp_rdata;
            end
        end
        tests_run++;
        if ({nresp, rd} !== {32'd1, 32'hDE22_BE44}) begin
            tests_failed++;
            $display("FAIL hold_second: got n=%0d rdata=%h expected n=1 rdata=de22be44", nresp, rd);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er; int lat; int guard; int nresp;
        do_txn(4'hF, 32'h0000_0020, 32'h1234_5678, rd, er, lat);
        req_valid = 1'b1; req_wen = 4'hF; req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = '0; req_addr = '0; req_wdata = '0;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, busy, resp_valid, resp_err, resp_rdata} !== {4'b1000, 32'h0}) begin
            tests_failed++;
            $display("FAIL rst_wait_outputs: got %b/%h expected 1000/0",
                     {req_ready, busy, resp_valid, resp_err}, resp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        nresp = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (resp_valid) nresp++;
        end
        tests_run++;
        if (nresp !== 0) begin
            tests_failed++;
            $display("FAIL rst_wait_noresp: got %0d responses expected 0", nresp);
        end
        do_txn(4'h0, 32'h0000_0020, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL rst_wait_nowrite: got %h expected 12345678", rd);
        end

        do_txn(4'hF, 32'h0000_0024, 32'hA5A5_A5A5, rd, er, lat);
        req_valid = 1'b1; req_wen = 4'hF; req_addr = 32'h24; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = '0; req_addr = '0; req_wdata = '0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        tests_run++;
        if (resp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_resp_reach: got resp_valid=%b expected 1", resp_valid);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, busy, resp_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL rst_resp_outputs: got %b expected 100", {req_ready, busy, resp_valid});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_txn(4'h0, 32'h0000_0024, 32'h0, rd, er, lat);
        tests_run++;
        if (rd !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL rst_resp_nowrite: got %h expected a5a5a5a5", rd);
        end
    endtask

    task automatic test_wait0();
        d0_req_valid = 1'b1; d0_req_wen = 4'hF; d0_req_addr = 32'h40; d0_req_wdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        tests_run++;
        if ({d0_req_ready, d0_busy, d0_resp_valid, d0_resp_err, d0_resp_rdata} !== {4'b0110, 32'h0}) begin
            tests_failed++;
            $display("FAIL w0_write_resp: got %b/%h expected 0110/0",
                     {d0_req_ready, d0_busy, d0_resp_valid, d0_resp_err}, d0_resp_rdata);
        end
        d0_req_wen = 4'h0; d0_req_wdata = '0;
        @(posedge clk); #1;
        tests_run++;
        if ({d0_req_ready, d0_busy, d0_resp_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL w0_idle: got %b expected 100", {d0_req_ready, d0_busy, d0_resp_valid});
        end
        @(posedge clk); #1;
        d0_req_valid = 1'b0;
        tests_run++;
        if ({d0_req_ready, d0_busy, d0_resp_valid, d0_resp_rdata} !== {3'b011, 32'h55AA_55AA}) begin
            tests_failed++;
            $display("FAIL w0_read_resp: got %b/%h expected 011/55aa55aa",
                     {d0_req_ready, d0_busy, d0_resp_valid}, d0_resp_rdata);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({d0_req_ready, d0_busy, d0_resp_valid, d0_resp_rdata} !== {3'b100, 32'h0}) begin
            tests_failed++;
            $display("FAIL w0_final_idle: got %b/%h expected 100/0",
                     {d0_req_ready, d0_busy, d0_resp_valid}, d0_resp_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_out_of_range();
        test_busy_hold();
        test_reset_midop();
        test_wait0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
